// File: rtl/bsort_drain_if.sv
// Output stream of the sorter drain: one element per valid/ready handshake,
// tagged with its sorter index and an end-of-stream marker.
interface bsort_drain_if #(
    parameter int W = 8
) ();
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic [3:0]   dout_idx;
    logic         dout_last;

    modport master (
        output dout,
        output dout_valid,
        output dout_idx,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_idx,
        input  dout_last,
        output dout_ready
    );
endinterface

// File: rtl/bsort_drain.sv
// Snapshots the bubble-sort result registers on the rising edge of complete,
// checks that they are ordered, and streams them out over a valid/ready handshake.
module bsort_drain #(
    parameter int W    = 8,
    parameter int N    = 8,
    parameter int DESC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               complete,
    input  logic [N*W-1:0]     din_flat,
    bsort_drain_if.master      dbus,
    output logic               busy,
    output logic               done,
    output logic               order_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_SEND,
        S_HOLD
    } state_t;

    localparam logic [3:0] START_IDX = (DESC != 0) ? 4'(N - 1) : 4'd0;
    localparam logic [3:0] LAST_CNT  = 4'(N - 1);

    function automatic logic unsorted(input logic [N*W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < N - 1; k++) begin
            if (v[k*W +: W] > v[(k+1)*W +: W]) bad = 1'b1;
        end
        return bad;
    endfunction

    state_t       state_q, state_d;
    logic         complete_q, complete_d;
    logic         armed_q, armed_d;
    logic [W-1:0] buf_q [N];
    logic [W-1:0] buf_d [N];
    logic [3:0]   idx_q, idx_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [W-1:0] dout_q, dout_d;
    logic         valid_q, valid_d;
    logic [3:0]   didx_q, didx_d;
    logic         last_q, last_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic         start;
    logic [3:0]   nxt_idx;
    logic [3:0]   sel;
    logic [W-1:0] sel_data;

    // armed_q blocks a level that was already high when reset released
    assign start   = complete & ~complete_q & armed_q;
    assign nxt_idx = (DESC != 0) ? idx_q - 4'd1 : idx_q + 4'd1;
    assign sel     = (state_q == S_CAPTURE) ? START_IDX : nxt_idx;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == 4'(k)) sel_data = buf_q[k];
        end
    end

    always_comb begin
        state_d    = state_q;
        complete_d = complete;
        armed_d    = armed_q | ~complete;
        buf_d      = buf_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        didx_d     = didx_q;
        last_d     = last_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int k = 0; k < N; k++) buf_d[k] = din_flat[k*W +: W];
                    if (unsorted(din_flat)) err_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                idx_d   = START_IDX;
                cnt_d   = 4'd0;
                dout_d  = sel_data;
                didx_d  = START_IDX;
                last_d  = 1'b0;
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (valid_q && dbus.dout_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        idx_d  = nxt_idx;
                        cnt_d  = cnt_q + 4'd1;
                        dout_d = sel_data;
                        didx_d = nxt_idx;
                        last_d = ((cnt_q + 4'd1) == LAST_CNT);
                    end
                end
            end
            S_HOLD: begin
                if (!complete) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            complete_q <= 1'b0;
            armed_q    <= 1'b0;
            for (int k = 0; k < N; k++) buf_q[k] <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            didx_q     <= '0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            complete_q <= complete_d;
            armed_q    <= armed_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            didx_q     <= didx_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign dbus.dout       = dout_q;
    assign dbus.dout_valid = valid_q;
    assign dbus.dout_idx   = didx_q;
    assign dbus.dout_last  = last_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign order_err       = err_q;

endmodule

// File: doc/bsort_drain.md
Name: bsort_drain

Overview:
- Reader/unloader for the 8-entry bubble-sort engine.
- When the sorter raises its complete flag, this block snapshots the parallel result registers D0..D7.
- It then streams the values one per handshake over a valid/ready interface, in ascending or descending order.
- It also checks that the snapshot is really sorted and flags any violation.
- It sits between the sorter and any downstream consumer (UART transmitter, FIFO, display driver).

Parameters:
- W, 8, data width of each element.
- N, 8, number of elements. Legal range 2..15; the index width is fixed at 4 bits.
- DESC, 0, 0 = emit D0 first (ascending); 1 = emit D(N-1) first (descending).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- complete  input  1  sort-finished flag from the sorter; level, stays high until the sorter is reset.
- din_flat  input  N*W  sorter results; element k occupies bits [k*W+W-1 : k*W] (D0 at the LSBs).
- dout  output  W  current output element.
- dout_valid  output  1  dout holds a valid element.
- dout_ready  input  1  consumer accepts dout this cycle.
- dout_idx  output  4  position of the current element in sorter numbering (0..N-1).
- dout_last  output  1  current element is the final one of the stream.
- busy  output  1  high in CAPTURE and SEND.
- done  output  1  one-cycle pulse after the final element is accepted.
- order_err  output  1  sticky; the snapshot was not non-decreasing.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, complete_q=0, buffer cleared. All outputs are 0: dout, dout_valid, dout_idx, dout_last, busy, done, order_err.
- Edge detect: complete_q registers complete each cycle. A start event is complete=1 and complete_q=0. A level that is already high when reset releases does not start a stream.
- FSM states: IDLE, CAPTURE, SEND, HOLD.
- IDLE:
  - On a start event, latch din_flat into an N x W buffer and go to CAPTURE.
  - Compare every adjacent pair buffer[k] > buffer[k+1] (unsigned). If any pair violates order, set order_err; it stays set until reset.
- CAPTURE (exactly 1 cycle):
  - Load idx = 0 (DESC=0) or N-1 (DESC=1).
  - Clear the sent-count; go to SEND.
  - Start-to-first-valid latency is 2 cycles.
- SEND:
  - dout_valid=1, dout=buffer[idx], dout_idx=idx, dout_last=(sent-count==N-1).
  - dout, dout_idx and dout_last are registered and stay stable while dout_valid=1 and dout_ready=0.
  - On dout_valid & dout_ready, if not last: idx steps +1 (DESC=0) or -1 (DESC=1) and the count increments. The next element is valid in the following cycle, giving a throughput of 1 element/cycle with ready held high.
  - On dout_valid & dout_ready with dout_last: drop dout_valid, pulse done for 1 cycle, go to HOLD.
- HOLD:
  - Wait for complete=0, then go to IDLE.
  - This prevents a still-high complete from restarting the stream.
- Simultaneous or abnormal events:
  - A start event outside IDLE is ignored.
  - If complete falls during CAPTURE or SEND, the stream still runs to completion from the snapshot. If complete is already low when the stream finishes, the block goes to HOLD and returns to IDLE next cycle.
  - din_flat changes after capture have no effect.
- Reset mid-stream: the stream aborts immediately, outputs clear, and no done pulse is produced.
- busy=1 in CAPTURE and SEND; 0 in IDLE and HOLD.
- Index arithmetic uses 4 bits. idx never wraps; last-element detection uses the count, not idx.

Test Plan:
- Reset, then drive sorted data 03,11,22,40,41,7F,A0,FF with a complete rising edge and ready held high, DESC=0. Required: valid 2 cycles after the edge; dout sequence 03..FF over 8 consecutive cycles; dout_idx 0..7; dout_last only with FF; done pulses once; order_err=0.
- Same data with DESC=1. Required: sequence FF,A0,7F,41,40,22,11,03; dout_idx 7..0; dout_last with 03.
- Backpressure: toggle ready 1,0,0,1,... Required: dout and dout_idx stable while ready=0; no element skipped or duplicated; exactly 8 transfers.
- Unsorted snapshot 05,02,... Required: order_err=1 from the capture cycle onward, streaming still completes normally, and order_err stays set until reset.
- Hold complete high after done. Required: no second stream. Then drop complete for 1 cycle and raise it again; required: a new stream with fresh data.
- Assert reset after the 3rd transfer. Required: dout_valid, busy and done stay 0 immediately and stay 0 until the next complete rising edge after reset release.
